// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line-level constants,
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..P-1 and strobes bit_done on the last cycle of
// each bit. A prescale of 0 is treated as 1. Held at zero while clear is high.
module uart_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] count_reg;
    logic [PRESCALE_WIDTH-1:0] last_count;

    assign last_count = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
    assign bit_done   = !clear && (count_reg == last_count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear || bit_done) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: start bit, LSB-first data, optional parity, stop bit.
// Build option UART_TX_TWO_STOP_EN selects two stop bits instead of one.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      parallel_data_valid,
    input  logic [DATA_WIDTH-1:0]     parallel_data,
    input  logic                      parity_en,
    input  logic                      parity_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      serial_data,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t               state_reg;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic [DATA_WIDTH-1:0]     shift_next;
    logic [IDX_W-1:0]          bit_idx_reg;
    logic                      parity_bit_reg;
    logic                      parity_en_reg;
    logic [PRESCALE_WIDTH-1:0] prescale_reg;
    logic                      serial_reg;
    logic                      busy_reg;
    logic                      timer_clear;
    logic                      bit_done;
`ifdef UART_TX_TWO_STOP_EN
    logic                      stop_idx_reg;
`endif

    assign serial_data = serial_reg;
    assign busy        = busy_reg;
    assign shift_next  = shift_reg >> 1;

    // Timer sits at zero through IDLE so the start bit gets a full period
    assign timer_clear = (state_reg == IDLE);

    uart_bit_timer #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .prescale(prescale_reg),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_idx_reg    <= '0;
            parity_bit_reg <= 1'b0;
            parity_en_reg  <= 1'b0;
            prescale_reg   <= PRESCALE_WIDTH'(1);
            serial_reg     <= LINE_IDLE;
            busy_reg       <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_idx_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    serial_reg <= LINE_IDLE;
                    busy_reg   <= 1'b0;
                    if (parallel_data_valid) begin
                        shift_reg      <= parallel_data;
                        parity_bit_reg <= (^parallel_data) ^ (parity_type == PARITY_ODD);
                        parity_en_reg  <= parity_en;
                        prescale_reg   <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
                        bit_idx_reg    <= '0;
`ifdef UART_TX_TWO_STOP_EN
                        stop_idx_reg   <= 1'b0;
`endif
                        serial_reg     <= START_BIT;
                        busy_reg       <= 1'b1;
                        state_reg      <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        serial_reg <= shift_reg[0];
                        state_reg  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx_reg == LAST_IDX) begin
                            if (parity_en_reg) begin
                                serial_reg <= parity_bit_reg;
                                state_reg  <= PARITY;
                            end else begin
                                serial_reg <= STOP_BIT;
                                state_reg  <= STOP;
                            end
                        end else begin
                            shift_reg   <= shift_next;
                            serial_reg  <= shift_next[0];
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        serial_reg <= STOP_BIT;
                        state_reg  <= STOP;
                    end
                end
                STOP: begin
                    if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!stop_idx_reg) begin
                            stop_idx_reg <= 1'b1;
                        end else begin
                            stop_idx_reg <= 1'b0;
                            serial_reg   <= LINE_IDLE;
                            busy_reg     <= 1'b0;
                            state_reg    <= IDLE;
                        end
`else
                        serial_reg <= LINE_IDLE;
                        busy_reg   <= 1'b0;
                        state_reg  <= IDLE;
`endif
                    end
                end
                default: begin
                    serial_reg <= LINE_IDLE;
                    busy_reg   <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

endmodule
